// File: rtl/mnist_pkg.sv
// Shared sizing constants and FSM state encoding for the MNIST output-layer
// classifier (per-class multiply-accumulate followed by an argmax scan).
package mnist_pkg;

   localparam int NUM_PIXELS  = 784;
   localparam int NUM_CLASSES = 10;
   localparam int ACC_W       = 28;

   localparam int PIX_W   = 8;
   localparam int WGT_W   = 8;
   localparam int BIAS_W  = 16;
   localparam int LOAD_W  = 12;
   localparam int DIGIT_W = 4;
   // An unsigned pixel becomes 9-bit signed; times an 8-bit signed weight
   // this gives a 17-bit signed product.
   localparam int PROD_W  = PIX_W + WGT_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_ARGMAX = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

endpackage

// File: rtl/mac_lane.sv
// One class lane: preload with the sign-extended bias, then accumulate
// pixel * weight on every enabled cycle. The sum wraps on overflow.
module mac_lane #(
   parameter int ACC_W = mnist_pkg::ACC_W
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                load_i,
   input  logic signed [mnist_pkg::BIAS_W-1:0] bias_i,
   input  logic                                en_i,
   input  logic        [mnist_pkg::PIX_W-1:0]  pixel_i,
   input  logic signed [mnist_pkg::WGT_W-1:0]  weight_i,
   output logic signed [ACC_W-1:0]             acc_o
);
   import mnist_pkg::*;

   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  acc_q;
   logic signed [ACC_W-1:0]  acc_d;

   // Next accumulator value: bias preload has priority over accumulation.
   always_comb begin
      prod  = $signed({1'b0, pixel_i}) * weight_i;
      acc_d = acc_q;
      if (load_i) begin
         acc_d = ACC_W'(bias_i);
      end else if (en_i) begin
         acc_d = acc_q + ACC_W'(prod);
      end
   end

   // Accumulator register with synchronous clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/neuron_mac_argmax.sv
// Output-layer classifier: streams one image of pixels through NUM_CLASSES
// parallel MAC lanes, then scans the lanes one per cycle for the largest
// score (ties keep the lowest class index) and pulses result_valid.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | bias writes accepted; start preloads lanes and clears count
//  ST_ACCUM  | each valid pixel is accumulated into every lane
//  ST_ARGMAX | one class compared per cycle, class 0 seeds the best
//  ST_DONE   | result registers valid, result_valid high for this cycle
module neuron_mac_argmax #(
   parameter int NUM_PIXELS  = mnist_pkg::NUM_PIXELS,
   parameter int NUM_CLASSES = mnist_pkg::NUM_CLASSES,
   parameter int ACC_W       = mnist_pkg::ACC_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [7:0]               pixel_data,
   input  logic                     pixel_valid,
   input  logic [8*NUM_CLASSES-1:0] weight_data,
   input  logic [11:0]              bias_load,
   input  logic [15:0]              bias_data,
   output logic                     busy,
   output logic                     result_valid,
   output logic [3:0]               result_digit,
   output logic [ACC_W-1:0]         result_score
);
   import mnist_pkg::*;

   localparam int CNT_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
   localparam int IDX_W = DIGIT_W;

   state_e                    state_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [IDX_W-1:0]          idx_q;
   logic signed [ACC_W-1:0]   best_q;
   logic [IDX_W-1:0]          best_idx_q;
   logic signed [BIAS_W-1:0]  bias_q [NUM_CLASSES];
   logic                      result_valid_q;
   logic [IDX_W-1:0]          result_digit_q;
   logic signed [ACC_W-1:0]   result_score_q;

   logic signed [ACC_W-1:0]   acc_w [NUM_CLASSES];
   logic                      lane_load;
   logic                      lane_en;
   logic signed [ACC_W-1:0]   cur_acc;
   logic                      take;
   logic signed [ACC_W-1:0]   best_d;
   logic [IDX_W-1:0]          best_idx_d;
   logic                      last_pix;
   logic                      last_cls;
   logic                      unused_load;

   // Bits of the bias strobe beyond the implemented classes have no target.
   assign unused_load = ^bias_load;

   assign lane_load = (state_q == ST_IDLE) && start;
   assign lane_en   = (state_q == ST_ACCUM) && pixel_valid;

   for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_lane
      mac_lane #(.ACC_W(ACC_W)) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .load_i   (lane_load),
         .bias_i   (bias_q[g]),
         .en_i     (lane_en),
         .pixel_i  (pixel_data),
         .weight_i (weight_data[8*g +: 8]),
         .acc_o    (acc_w[g])
      );
   end

   // Argmax step: class 0 always seeds, later classes win only when strictly greater.
   always_comb begin
      cur_acc    = acc_w[idx_q];
      take       = (idx_q == '0) || (cur_acc > best_q);
      best_d     = take ? cur_acc : best_q;
      best_idx_d = take ? idx_q : best_idx_q;
      last_pix   = (cnt_q == CNT_W'(NUM_PIXELS - 1));
      last_cls   = (idx_q == IDX_W'(NUM_CLASSES - 1));
   end

   // Sequencer, bias register file and registered result outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         idx_q          <= '0;
         best_q         <= '0;
         best_idx_q     <= '0;
         result_valid_q <= 1'b0;
         result_digit_q <= '0;
         result_score_q <= '0;
         for (int k = 0; k < NUM_CLASSES; k++) begin
            bias_q[k] <= '0;
         end
      end else begin
         result_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               for (int k = 0; k < NUM_CLASSES; k++) begin
                  if (bias_load[k]) begin
                     bias_q[k] <= bias_data;
                  end
               end
               if (start) begin
                  cnt_q   <= '0;
                  state_q <= ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (pixel_valid) begin
                  cnt_q <= cnt_q + 1'b1;
                  if (last_pix) begin
                     idx_q   <= '0;
                     state_q <= ST_ARGMAX;
                  end
               end
            end
            ST_ARGMAX: begin
               best_q     <= best_d;
               best_idx_q <= best_idx_d;
               idx_q      <= idx_q + 1'b1;
               if (last_cls) begin
                  result_valid_q <= 1'b1;
                  result_digit_q <= best_idx_d;
                  result_score_q <= best_d;
                  state_q        <= ST_DONE;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy         = (state_q != ST_IDLE);
   assign result_valid = result_valid_q;
   assign result_digit = result_digit_q;
   assign result_score = result_score_q;

endmodule

// File: tb/tb_neuron_mac_argmax.sv
// Directed bench for neuron_mac_argmax with a plain-arithmetic reference model
// of the class scores and an every-cycle monitor of busy / result_valid.
module tb_neuron_mac_argmax;

   localparam int NP = 784;
   localparam int NC = 10;
   localparam int AW = 28;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start;
   logic [7:0]      pixel_data;
   logic            pixel_valid;
   logic [8*NC-1:0] weight_data;
   logic [11:0]     bias_load;
   logic [15:0]     bias_data;
   logic            busy;
   logic            result_valid;
   logic [3:0]      result_digit;
   logic [AW-1:0]   result_score;

   always #5 clk = ~clk;

   neuron_mac_argmax #(.NUM_PIXELS(NP), .NUM_CLASSES(NC), .ACC_W(AW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .pixel_data   (pixel_data),
      .pixel_valid  (pixel_valid),
      .weight_data  (weight_data),
      .bias_load    (bias_load),
      .bias_data    (bias_data),
      .busy         (busy),
      .result_valid (result_valid),
      .result_digit (result_digit),
      .result_score (result_score)
   );

   int     cyc = 0;
   int     checks = 0;
   int     errors = 0;
   bit     chk_en = 1'b0;
   int     busy_from = 0;
   int     busy_to = -1;
   int     valid_cyc = -1;
   int     pulses = 0;
   int     exp_digit = 0;
   longint exp_score = 0;
   int     m_bias [NC];
   longint m_acc [NC];
   bit     exp_busy;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Every-cycle monitor: busy window, exact result_valid cycle, result payload.
   always @(negedge clk) begin
      if (chk_en) begin
         exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
         chk("busy", longint'(busy), longint'(exp_busy));
         chk("result_valid", longint'(result_valid), longint'(cyc == valid_cyc));
         if (result_valid === 1'b1) begin
            pulses++;
            chk("pulse_digit", longint'(result_digit), longint'(exp_digit));
            chk("pulse_score", longint'($signed(result_score)), exp_score);
         end
      end
   end

   function automatic int pv(input int mode, input int p);
      case (mode)
         2, 3:    return 255;
         4:       return (p * 37 + 11) % 256;
         default: return (p * 53) % 256;
      endcase
   endfunction

   function automatic int wv(input int mode, input int p, input int k);
      case (mode)
         2:       return (k == 3) ? 127 : 0;
         3:       return (k == 5) ? -128 : 0;
         4:       return ((p * 13 + k * 29 + 5) % 256) - 128;
         default: return 0;
      endcase
   endfunction

   function automatic longint wrap(input longint x);
      longint m;
      m = x & ((longint'(1) << AW) - 1);
      if (m >= (longint'(1) << (AW - 1))) m = m - (longint'(1) << AW);
      return m;
   endfunction

   // Reference: score_k = bias_k + sum(pixel * weight_k), then first maximum.
   task automatic model(input int mode);
      longint s;
      for (int k = 0; k < NC; k++) begin
         s = m_bias[k];
         for (int p = 0; p < NP; p++) s += longint'(pv(mode, p)) * longint'(wv(mode, p, k));
         m_acc[k] = wrap(s);
      end
      exp_digit = 0;
      exp_score = m_acc[0];
      for (int k = 1; k < NC; k++) begin
         if (m_acc[k] > exp_score) begin
            exp_digit = k;
            exp_score = m_acc[k];
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_biases();
      for (int k = 0; k < NC; k++) begin
         bias_load = 12'(1 << k);
         bias_data = 16'(m_bias[k]);
         tick();
      end
      bias_load = 12'hC00;
      bias_data = 16'h7FFF;
      tick();
      bias_load = '0;
   endtask

   task automatic drive_pixel(input int mode, input int p);
      pixel_data = 8'(pv(mode, p));
      for (int k = 0; k < NC; k++) weight_data[8*k +: 8] = 8'(wv(mode, p, k));
   endtask

   // One image. gap inserts idle cycles (with junk data and stray starts);
   // abort_at >= 0 asserts reset right after that pixel is accepted.
   task automatic run_image(input int mode, input bit gap, input int abort_at);
      int last;
      model(mode);
      pulses    = 0;
      valid_cyc = -1;
      last      = 0;
      start     = 1'b1;
      busy_from = cyc + 1;
      busy_to   = 1000000;
      tick();
      start = 1'b0;
      for (int p = 0; p < NP; p++) begin
         if (gap && p > 0) begin
            pixel_valid = 1'b0;
            pixel_data  = 8'($urandom);
            for (int k = 0; k < NC; k++) weight_data[8*k +: 8] = 8'($urandom);
            start = (p % 100 == 1);
            tick();
            start = 1'b0;
         end
         drive_pixel(mode, p);
         pixel_valid = 1'b1;
         if (mode == 4 && p == 5) begin
            bias_load = 12'hFFF;
            bias_data = 16'h7FFF;
         end
         last = cyc;
         tick();
         bias_load = '0;
         if (p == abort_at) begin
            pixel_valid = 1'b0;
            rst_n       = 1'b0;
            busy_to     = cyc;
            tick();
            chk("abort_digit", longint'(result_digit), 0);
            chk("abort_score", longint'($signed(result_score)), 0);
            tick();
            rst_n = 1'b1;
            repeat (15) tick();
            chk("abort_pulses", longint'(pulses), 0);
            return;
         end
      end
      pixel_valid = 1'b0;
      valid_cyc   = last + NC + 1;
      busy_to     = last + NC + 1;
      if (gap) begin
         start = 1'b1;
         tick();
         start = 1'b0;
      end
      repeat (15) tick();
      chk("pulse_count", longint'(pulses), 1);
      chk("hold_digit", longint'(result_digit), longint'(exp_digit));
      chk("hold_score", longint'($signed(result_score)), exp_score);
   endtask

   initial begin
      rst_n       = 1'b0;
      start       = 1'b0;
      pixel_data  = '0;
      pixel_valid = 1'b0;
      weight_data = '0;
      bias_load   = '0;
      bias_data   = '0;
      repeat (3) tick();
      chk_en = 1'b1;
      tick();
      chk("reset_digit", longint'(result_digit), 0);
      chk("reset_score", longint'($signed(result_score)), 0);
      rst_n = 1'b1;
      tick();

      // zero weights, bias 10*k: highest bias wins
      for (int k = 0; k < NC; k++) m_bias[k] = 10 * k;
      load_biases();
      run_image(0, 1'b0, -1);
      chk("t1_model_digit", longint'(exp_digit), 9);
      chk("t1_model_score", exp_score, 90);
      chk("t1_digit", longint'(result_digit), 9);
      chk("t1_score", longint'($signed(result_score)), 90);

      // all zero: tie resolves to class 0
      for (int k = 0; k < NC; k++) m_bias[k] = 0;
      load_biases();
      run_image(1, 1'b0, -1);
      chk("t2_digit", longint'(result_digit), 0);
      chk("t2_score", longint'($signed(result_score)), 0);

      // single positive weight on class 3
      run_image(2, 1'b0, -1);
      chk("t3_model_score", exp_score, 25389840);
      chk("t3_digit", longint'(result_digit), 3);
      chk("t3_score", longint'($signed(result_score)), 25389840);

      // large negative class 5, others at -1
      for (int k = 0; k < NC; k++) m_bias[k] = (k == 5) ? 0 : -1;
      load_biases();
      run_image(3, 1'b0, -1);
      chk("t4_model_acc5", m_acc[5], -25589760);
      chk("t4_digit", longint'(result_digit), 0);
      chk("t4_score", longint'($signed(result_score)), -1);

      // gapped pixel stream with stray start pulses
      for (int k = 0; k < NC; k++) m_bias[k] = 0;
      load_biases();
      run_image(2, 1'b1, -1);
      chk("t5_digit", longint'(result_digit), 3);
      chk("t5_score", longint'($signed(result_score)), 25389840);

      // varied data; junk pixels in IDLE and bias writes during ACCUM are ignored
      for (int k = 0; k < NC; k++) m_bias[k] = 1000 * k - 4000;
      load_biases();
      for (int i = 0; i < 3; i++) begin
         pixel_valid = 1'b1;
         pixel_data  = 8'($urandom);
         tick();
      end
      pixel_valid = 1'b0;
      run_image(4, 1'b0, -1);

      // reset after pixel 400 aborts; reload biases and classify again
      for (int k = 0; k < NC; k++) m_bias[k] = 10 * k;
      load_biases();
      run_image(2, 1'b0, 400);
      load_biases();
      run_image(0, 1'b0, -1);
      chk("t7_digit", longint'(result_digit), 9);
      chk("t7_score", longint'($signed(result_score)), 90);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
